// File: rtl/pes_array_if.sv
// pes_array_if: run/config bus plus the four per-row LSU <-> CBG links.
// PE_inst sets the configuration word width (24 unless already defined).
`ifndef PE_inst
`define PE_inst 24
`endif

interface pes_array_if;
  logic                run;
  logic [8:0]          init_PE_array;
  logic [`PE_inst-1:0] PE_config;
  logic [32:0]         CBG_to_LSU_bus_0;
  logic [32:0]         CBG_to_LSU_bus_1;
  logic [32:0]         CBG_to_LSU_bus_2;
  logic [32:0]         CBG_to_LSU_bus_3;
  logic                R_request_0;
  logic                R_request_1;
  logic                R_request_2;
  logic                R_request_3;
  logic                W_request_0;
  logic                W_request_1;
  logic                W_request_2;
  logic                W_request_3;
  logic [31:0]         LSU_addr_bus_0;
  logic [31:0]         LSU_addr_bus_1;
  logic [31:0]         LSU_addr_bus_2;
  logic [31:0]         LSU_addr_bus_3;

  modport master (
    output run, init_PE_array, PE_config,
    output CBG_to_LSU_bus_0, CBG_to_LSU_bus_1,
    output CBG_to_LSU_bus_2, CBG_to_LSU_bus_3,
    input  R_request_0, R_request_1, R_request_2, R_request_3,
    input  W_request_0, W_request_1, W_request_2, W_request_3,
    input  LSU_addr_bus_0, LSU_addr_bus_1,
    input  LSU_addr_bus_2, LSU_addr_bus_3
  );

  modport slave (
    input  run, init_PE_array, PE_config,
    input  CBG_to_LSU_bus_0, CBG_to_LSU_bus_1,
    input  CBG_to_LSU_bus_2, CBG_to_LSU_bus_3,
    output R_request_0, R_request_1, R_request_2, R_request_3,
    output W_request_0, W_request_1, W_request_2, W_request_3,
    output LSU_addr_bus_0, LSU_addr_bus_1,
    output LSU_addr_bus_2, LSU_addr_bus_3
  );
endinterface

// File: rtl/pes_array.sv
// pes_array: 4x4 CGRA of ALU elements with one LSU per row on the west edge.
// Define PE_MUL_EN to give op 3 a 32x32 low-word multiply (else pass A).
module pes_array (
  input logic        clk,
  input logic        rst,
  pes_array_if.slave bus
);

  logic [16:0] cfg [4][4];
  logic [10:0] lsu_cfg [4];
  logic [31:0] pe [4][4];
  logic [31:0] res [4][4];
  logic [31:0] rd [4];
  logic [31:0] addr [4];
  logic [32:0] cbg [4];
  logic [3:0]  row_sel;
  logic [3:0]  col_sel;
  logic        lsu_sel;
  logic        active;
  logic [3:0]  req_r;
  logic [3:0]  req_w;
  logic [31:0] abus [4];

  assign row_sel = {bus.init_PE_array[5], bus.init_PE_array[6],
                    bus.init_PE_array[7], bus.init_PE_array[8]};
  assign col_sel = {bus.init_PE_array[0], bus.init_PE_array[1],
                    bus.init_PE_array[2], bus.init_PE_array[3]};
  assign lsu_sel = bus.init_PE_array[4];

  assign cbg[0] = bus.CBG_to_LSU_bus_0;
  assign cbg[1] = bus.CBG_to_LSU_bus_1;
  assign cbg[2] = bus.CBG_to_LSU_bus_2;
  assign cbg[3] = bus.CBG_to_LSU_bus_3;

  function automatic logic [31:0] pick(
    input logic [1:0]  s,
    input logic [31:0] n,
    input logic [31:0] so,
    input logic [31:0] w,
    input logic [31:0] e
  );
    unique case (s)
      2'd0: return n;
      2'd1: return so;
      2'd2: return w;
      default: return e;
    endcase
  endfunction

  // cfg keeps word bits [23:7]: op[16:13] a[12:11] b[10:9] imm[8:1] en[0]
  function automatic logic [31:0] alu(
    input logic [16:0] c,
    input logic [31:0] cur,
    input logic [31:0] n,
    input logic [31:0] so,
    input logic [31:0] w,
    input logic [31:0] e
  );
    logic [31:0] a;
    logic [31:0] b;
    a = pick(c[12:11], n, so, w, e);
    b = c[0] ? {24'd0, c[8:1]} : pick(c[10:9], n, so, w, e);
    case (c[16:13])
      4'd0: return cur;
      4'd1: return a + b;
      4'd2: return a - b;
`ifdef PE_MUL_EN
      4'd3: return a * b;
`endif
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [31:0] n;
      logic [31:0] so;
      logic [31:0] w;
      logic [31:0] e;
      if (r == 0) begin : g_n0
        assign n = '0;
      end else begin : g_n
        assign n = pe[r-1][c];
      end
      if (r == 3) begin : g_s0
        assign so = '0;
      end else begin : g_s
        assign so = pe[r+1][c];
      end
      if (c == 0) begin : g_w0
        assign w = rd[r];
      end else begin : g_w
        assign w = pe[r][c-1];
      end
      if (c == 3) begin : g_e0
        assign e = '0;
      end else begin : g_e
        assign e = pe[r][c+1];
      end
      assign res[r][c] = alu(cfg[r][c], pe[r][c], n, so, w, e);
    end
  end

  // Activity flag: latched by run, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else if (bus.run) active <= 1'b1;
  end

  // Config load: broadcast the word to every selected PE/LSU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        lsu_cfg[r] <= '0;
        for (int c = 0; c < 4; c++) cfg[r][c] <= '0;
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (row_sel[r]) begin
          if (lsu_sel) lsu_cfg[r] <= bus.PE_config[10:0];
          for (int c = 0; c < 4; c++)
            if (col_sel[c]) cfg[r][c] <= bus.PE_config[23:7];
        end
      end
    end
  end

  // PE output registers advance only while the array is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) pe[r][c] <= '0;
    end else if (active) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) pe[r][c] <= res[r][c];
    end
  end

  // LSU read capture and address generation per row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        rd[r]   <= '0;
        addr[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (active && lsu_cfg[r][10] && cbg[r][32])
          rd[r] <= cbg[r][31:0];
        if (bus.run && !lsu_cfg[r][5])
          addr[r] <= {27'd0, lsu_cfg[r][4:0]};
        else if (active)
          addr[r] <= lsu_cfg[r][5] ? pe[r][3]
                   : addr[r] + {29'd0, lsu_cfg[r][8:6]};
      end
    end
  end

  // Requests and address are only driven while running.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      req_r[r] = active & lsu_cfg[r][10];
      req_w[r] = active & lsu_cfg[r][9];
      abus[r]  = active ? addr[r] : 32'd0;
    end
  end

  assign bus.R_request_0 = req_r[0];
  assign bus.R_request_1 = req_r[1];
  assign bus.R_request_2 = req_r[2];
  assign bus.R_request_3 = req_r[3];
  assign bus.W_request_0 = req_w[0];
  assign bus.W_request_1 = req_w[1];
  assign bus.W_request_2 = req_w[2];
  assign bus.W_request_3 = req_w[3];
  assign bus.LSU_addr_bus_0 = abus[0];
  assign bus.LSU_addr_bus_1 = abus[1];
  assign bus.LSU_addr_bus_2 = abus[2];
  assign bus.LSU_addr_bus_3 = abus[3];

endmodule

// File: tb/tb_pes_array.sv
// tb_pes_array: directed scenarios plus a randomized run against a
// behavioural array model.
module tb_pes_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pes_array_if ifc ();

  pes_array dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  logic [32:0] cbg [4];
  logic [31:0] ao [4];
  logic        ro [4];
  logic        wo [4];

  assign ifc.CBG_to_LSU_bus_0 = cbg[0];
  assign ifc.CBG_to_LSU_bus_1 = cbg[1];
  assign ifc.CBG_to_LSU_bus_2 = cbg[2];
  assign ifc.CBG_to_LSU_bus_3 = cbg[3];
  assign ao[0] = ifc.LSU_addr_bus_0;
  assign ao[1] = ifc.LSU_addr_bus_1;
  assign ao[2] = ifc.LSU_addr_bus_2;
  assign ao[3] = ifc.LSU_addr_bus_3;
  assign ro[0] = ifc.R_request_0;
  assign ro[1] = ifc.R_request_1;
  assign ro[2] = ifc.R_request_2;
  assign ro[3] = ifc.R_request_3;
  assign wo[0] = ifc.W_request_0;
  assign wo[1] = ifc.W_request_1;
  assign wo[2] = ifc.W_request_2;
  assign wo[3] = ifc.W_request_3;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [23:0] m_pcfg [4][4];
  logic [10:0] m_lcfg [4];
  logic [31:0] m_pe [4][4];
  logic [31:0] m_rd [4];
  logic [31:0] m_addr [4];
  logic        m_act;

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      m_lcfg[r] = '0;
      m_rd[r]   = '0;
      m_addr[r] = '0;
      for (int c = 0; c < 4; c++) begin
        m_pcfg[r][c] = '0;
        m_pe[r][c]   = '0;
      end
    end
    m_act = 1'b0;
  endtask

  function automatic logic [31:0] m_view(int r, int c);
    if (r < 0 || r > 3 || c > 3) return 32'd0;
    if (c < 0) return m_rd[r];
    return m_pe[r][c];
  endfunction

  function automatic logic [31:0] m_src(int r, int c, logic [1:0] s);
    case (s)
      2'd0: return m_view(r - 1, c);
      2'd1: return m_view(r + 1, c);
      2'd2: return m_view(r, c - 1);
      default: return m_view(r, c + 1);
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] np [4][4];
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] w;
    logic [10:0] l;
    logic [8:0]  sel;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w = m_pcfg[r][c];
        a = m_src(r, c, w[19:18]);
        b = w[7] ? {24'd0, w[15:8]} : m_src(r, c, w[17:16]);
        case (w[23:20])
          4'd0: np[r][c] = m_pe[r][c];
          4'd1: np[r][c] = a + b;
          4'd2: np[r][c] = a - b;
`ifdef PE_MUL_EN
          4'd3: np[r][c] = a * b;
`endif
          4'd4: np[r][c] = a & b;
          4'd5: np[r][c] = a | b;
          4'd6: np[r][c] = a ^ b;
          4'd7: np[r][c] = a << (b % 32);
          4'd8: np[r][c] = a >> (b % 32);
          default: np[r][c] = a;
        endcase
      end
    end
    for (int r = 0; r < 4; r++) begin
      l = m_lcfg[r];
      if (ifc.run && !l[5]) m_addr[r] = 32'(l[4:0]);
      else if (m_act) m_addr[r] = l[5] ? m_pe[r][3] : m_addr[r] + 32'(l[8:6]);
      if (m_act && l[10] && cbg[r][32]) m_rd[r] = cbg[r][31:0];
    end
    if (m_act) m_pe = np;
    sel = ifc.init_PE_array;
    for (int r = 0; r < 4; r++) begin
      if (sel[8-r]) begin
        if (sel[4]) m_lcfg[r] = ifc.PE_config[10:0];
        for (int c = 0; c < 4; c++)
          if (sel[3-c]) m_pcfg[r][c] = ifc.PE_config;
      end
    end
    if (ifc.run) m_act = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifc.run = 1'b0;
    ifc.init_PE_array = '0;
    ifc.PE_config = '0;
    for (int r = 0; r < 4; r++) cbg[r] = '0;
    step();
    step();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic load(input logic [8:0] sel, input logic [23:0] w);
    ifc.init_PE_array = sel;
    ifc.PE_config = w;
    step();
    ifc.init_PE_array = '0;
    ifc.PE_config = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifc.run = 1'b1;
    ifc.init_PE_array = 9'h1ff;
    ifc.PE_config = 24'($urandom);
    for (int r = 0; r < 4; r++) cbg[r] = {1'b1, 32'($urandom)};
    for (int k = 0; k < 3; k++) begin
      step();
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (ro[r] !== 1'b0 || wo[r] !== 1'b0 || ao[r] !== 32'd0) begin
          errors++;
          $display("FAIL reset row%0d: r=%b w=%b addr=%0d, need 0/0/0",
                   r, ro[r], wo[r], ao[r]);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_counter();
    do_reset();
    load(9'h110, 24'h000444);
    ifc.run = 1'b1;
    step();
    ifc.run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ro[0] !== 1'b1 || wo[0] !== 1'b0 || ao[0] !== 32'(4 + k)) begin
        errors++;
        $display("FAIL counter cyc%0d: r=%b w=%b addr=%0d, need 1/0/%0d",
                 k, ro[0], wo[0], ao[0], 4 + k);
      end
      for (int r = 1; r < 4; r++) begin
        checks++;
        if (ro[r] !== 1'b0 || wo[r] !== 1'b0 || ao[r] !== 32'd0) begin
          errors++;
          $display("FAIL counter_idle row%0d: r=%b w=%b addr=%0d, need 0",
                   r, ro[r], wo[r], ao[r]);
        end
      end
      step();
    end
  endtask

  task automatic run_row(input logic [23:0] w0, input logic [31:0] exp,
                         input string name);
    int n;
    do_reset();
    load(9'h108, w0);
    load(9'h107, 24'h980000);
    load(9'h110, 24'h000620);
    cbg[0] = {1'b1, 32'd10};
    ifc.run = 1'b1;
    step();
    ifc.run = 1'b0;
    n = 0;
    while (ao[0] !== exp && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (ao[0] !== exp || n > 6) begin
      errors++;
      $display("FAIL %s settle: addr=%0d after %0d cycles, need %0d in <=6",
               name, ao[0], n, exp);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ro[0] !== 1'b1 || wo[0] !== 1'b1 || ao[0] !== exp) begin
        errors++;
        $display("FAIL %s hold: r=%b w=%b addr=%0d, need 1/1/%0d",
                 name, ro[0], wo[0], ao[0], exp);
      end
    end
  endtask

  task automatic test_row_datapath();
    run_row(24'h180180, 32'd11, "row_path");
  endtask

  task automatic test_valid_gating();
    cbg[0] = {1'b0, 32'd99};
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (ao[0] !== 32'd11) begin
        errors++;
        $display("FAIL valid_gate cyc%0d: addr=%0d, need 11", k, ao[0]);
      end
    end
  endtask

  task automatic test_multiply();
`ifdef PE_MUL_EN
    run_row(24'h380380, 32'd30, "multiply");
`else
    run_row(24'h380380, 32'd10, "multiply");
`endif
  endtask

  task automatic test_midrun_reset();
    #3;
    rst = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (ro[r] !== 1'b0 || wo[r] !== 1'b0 || ao[r] !== 32'd0) begin
        errors++;
        $display("FAIL midrun_reset row%0d: r=%b w=%b addr=%0d, need 0",
                 r, ro[r], wo[r], ao[r]);
      end
    end
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ro[0] !== 1'b0 || wo[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: r=%b w=%b, need 0/0",
                 k, ro[0], wo[0]);
      end
    end
    ifc.run = 1'b1;
    step();
    ifc.run = 1'b0;
    step();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (ro[r] !== 1'b0 || wo[r] !== 1'b0 || ao[r] !== 32'd0) begin
        errors++;
        $display("FAIL rerun_cleared row%0d: r=%b w=%b addr=%0d, need 0",
                 r, ro[r], wo[r], ao[r]);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] w;
    logic        er;
    logic        ew;
    logic [31:0] ea;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      w = 24'($urandom);
      w[23:20] = 4'($urandom_range(0, 10));
      ifc.PE_config = w;
      ifc.init_PE_array = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'd0;
      ifc.run = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < 4; r++)
        cbg[r] = {1'($urandom), 32'($urandom)};
      step();
      model_step();
      for (int r = 0; r < 4; r++) begin
        er = m_act & m_lcfg[r][10];
        ew = m_act & m_lcfg[r][9];
        ea = m_act ? m_addr[r] : 32'd0;
        checks++;
        if (ro[r] !== er) begin
          errors++;
          $display("FAIL rand_rreq cyc%0d row%0d: got %b, need %b",
                   k, r, ro[r], er);
        end
        checks++;
        if (wo[r] !== ew) begin
          errors++;
          $display("FAIL rand_wreq cyc%0d row%0d: got %b, need %b",
                   k, r, wo[r], ew);
        end
        checks++;
        if (ao[r] !== ea) begin
          errors++;
          $display("FAIL rand_addr cyc%0d row%0d: got %h, need %h",
                   k, r, ao[r], ea);
        end
      end
    end
    ifc.run = 1'b0;
    ifc.init_PE_array = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ifc.run = 1'b0;
    ifc.init_PE_array = '0;
    ifc.PE_config = '0;
    for (int r = 0; r < 4; r++) cbg[r] = '0;
    model_reset();
    #2;
    test_reset();
    test_counter();
    test_row_datapath();
    test_valid_gating();
    test_multiply();
    test_midrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
